// File: rtl/cb_uart_pkg.sv
// cb_uart_pkg: state encodings and frame limits
// shared by the UART transmitter and receiver.
package cb_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_state_t;

   localparam int DATA_W_MIN = 5;
   localparam int DATA_W_MAX = 9;

endpackage

// File: rtl/cb_uart_tx.sv
// cb_uart_tx: LSB-first UART frame serializer
// paced by the baud_en bit tick.
module cb_uart_tx
   import cb_uart_pkg::*;
#(
   parameter int U_DLY  = 1,
   parameter int DATA_W = 8
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              baud_en,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              stop_2,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              txd
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   // An illegal configuration simply never accepts a word.
   localparam bit CFG_OK = (DATA_W >= DATA_W_MIN) &&
                           (DATA_W <= DATA_W_MAX) &&
                           (U_DLY >= 0);

   uart_state_t       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pen_q, pen_d;
   logic              par_q, par_d;
   logic              s2_q, s2_d;
   logic              scnt_q, scnt_d;
   logic              txd_q, txd_d;
   logic              done_q, done_d;
   logic              accept;

   assign tx_ready = (state_q == IDLE) & ~done_q & CFG_OK;
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = done_q;
   assign txd      = txd_q;
   assign accept   = tx_valid & tx_ready;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         s2_q    <= 1'b0;
         scnt_q  <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
         s2_q    <= s2_d;
         scnt_q  <= scnt_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      pen_d   = pen_q;
      par_d   = par_q;
      s2_d    = s2_q;
      scnt_d  = scnt_q;
      txd_d   = txd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (accept) begin
               shift_d = tx_data;
               pen_d   = parity_en;
               par_d   = (^tx_data) ^ parity_odd;
               s2_d    = stop_2;
               state_d = WAIT;
            end
         end
         // A tick in the accept cycle is seen in IDLE, so it never
         // shortens the start bit.
         WAIT: begin
            if (baud_en) begin
               txd_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_en) begin
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               cnt_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_en) begin
               if (cnt_q == LAST) begin
                  cnt_d  = '0;
                  scnt_d = 1'b0;
                  if (pen_q) begin
                     txd_d   = par_q;
                     state_d = PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (baud_en) begin
               txd_d   = 1'b1;
               scnt_d  = 1'b0;
               state_d = STOP;
            end
         end
         STOP: begin
            txd_d = 1'b1;
            if (baud_en) begin
               if (s2_q && !scnt_q) begin
                  scnt_d = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule
